// File: rtl/mem_frame_pkg.sv
// Shared definitions for mem_frame_arbiter: 97-bit frame beat layout and grant FSM encoding.
package mem_frame_pkg;

    localparam int FRAME_WIDTH = 97;

    localparam int FR_ADDR_LSB = 0;
    localparam int FR_DATA_LSB = 22;
    localparam int FR_WR_BIT   = 86;
    localparam int FR_SOF_BIT  = 87;
    localparam int FR_EOF_BIT  = 88;
    localparam int FR_LEN_LSB  = 89;

    localparam int FR_ADDR_W = 22;
    localparam int FR_DATA_W = 64;
    localparam int FR_LEN_W  = 8;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        GNT_W = 2'd1,
        GNT_R = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [FR_LEN_W-1:0]  len;
        logic                 eof;
        logic                 sof;
        logic                 wr;
        logic [FR_DATA_W-1:0] data;
        logic [FR_ADDR_W-1:0] addr;
    } frame_beat_t;

    function automatic logic beat_sof(input logic [FRAME_WIDTH-1:0] beat);
        return beat[FR_SOF_BIT];
    endfunction

    function automatic logic beat_eof(input logic [FRAME_WIDTH-1:0] beat);
        return beat[FR_EOF_BIT];
    endfunction

endpackage

// File: rtl/mem_frame_arbiter_frame_tracker.sv
// Follows frame boundaries on the granted beat stream: in-frame state, end-of-frame
// handshakes and sof framing errors.
module mem_frame_arbiter_frame_tracker (
    input  logic clk,
    input  logic rst,
    input  logic beat_valid,
    input  logic beat_ready,
    input  logic beat_sof,
    input  logic beat_eof,
    output logic in_frame,
    output logic eof_hs,
    output logic sof_err
);

    logic hs;
    logic in_frame_d;
    logic in_frame_q;

    always_comb begin
        hs         = beat_valid & beat_ready;
        in_frame_d = in_frame_q;
        if (hs) begin
            in_frame_d = ~beat_eof;
        end
        eof_hs  = hs & beat_eof;
        // outside a frame every beat must open one; inside, none may
        sof_err = hs & (in_frame_q ? beat_sof : ~beat_sof);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_frame_q <= 1'b0;
        end else begin
            in_frame_q <= in_frame_d;
        end
    end

    assign in_frame = in_frame_q;

endmodule

// File: rtl/mem_frame_arbiter.sv
// Frame-locked round-robin arbiter between the AXI write and read frame sources.
// Optional ARB_WR_PRIORITY_EN: fixed write priority, frame limit applies to reads only.
module mem_frame_arbiter #(
    parameter int FRAME_WIDTH  = mem_frame_pkg::FRAME_WIDTH,
    parameter int GRANT_FRAMES = 4,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   axi2arb_wframe_valid,
    output logic                   axi2arb_wframe_ready,
    input  logic [FRAME_WIDTH-1:0] axi2arb_wframe_data,
    input  logic                   axi2arb_rframe_valid,
    output logic                   axi2arb_rframe_ready,
    input  logic [FRAME_WIDTH-1:0] axi2arb_rframe_data,
    output logic                   arb2mc_frame_valid,
    input  logic                   arb2mc_frame_ready,
    output logic [FRAME_WIDTH-1:0] arb2mc_frame_data,
    output logic                   arb_gnt_wr,
    output logic                   arb_gnt_rd,
    output logic                   arb_err
);

    import mem_frame_pkg::*;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(GRANT_FRAMES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

`ifdef ARB_WR_PRIORITY_EN
    localparam bit WR_PRIO = 1'b1;
`else
    localparam bit WR_PRIO = 1'b0;
`endif

    arb_state_e           state_q, state_d;
    logic                 prio_rd_q, prio_rd_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic                 err_q, err_d;
    logic                 gnt_wr_q, gnt_wr_d;
    logic                 gnt_rd_q, gnt_rd_d;

    logic in_frame;
    logic eof_hs;
    logic sof_err;

    // Granted source is passed straight through; the other source sees no ready.
    always_comb begin
        arb2mc_frame_valid   = 1'b0;
        arb2mc_frame_data    = '0;
        axi2arb_wframe_ready = 1'b0;
        axi2arb_rframe_ready = 1'b0;
        case (state_q)
            GNT_W: begin
                arb2mc_frame_valid   = axi2arb_wframe_valid;
                arb2mc_frame_data    = axi2arb_wframe_data;
                axi2arb_wframe_ready = arb2mc_frame_ready;
            end
            GNT_R: begin
                arb2mc_frame_valid   = axi2arb_rframe_valid;
                arb2mc_frame_data    = axi2arb_rframe_data;
                axi2arb_rframe_ready = arb2mc_frame_ready;
            end
            default: ;
        endcase
    end

    mem_frame_arbiter_frame_tracker u_frame_tracker (
        .clk        (clk),
        .rst        (rst),
        .beat_valid (arb2mc_frame_valid),
        .beat_ready (arb2mc_frame_ready),
        .beat_sof   (arb2mc_frame_data[FR_SOF_BIT]),
        .beat_eof   (arb2mc_frame_data[FR_EOF_BIT]),
        .in_frame   (in_frame),
        .eof_hs     (eof_hs),
        .sof_err    (sof_err)
    );

    always_comb begin
        state_d     = state_q;
        prio_rd_d   = prio_rd_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q | sof_err;

        case (state_q)
            ARB: begin
                if (axi2arb_wframe_valid && axi2arb_rframe_valid) begin
                    state_d = (prio_rd_q && !WR_PRIO) ? GNT_R : GNT_W;
                end else if (axi2arb_wframe_valid) begin
                    state_d = GNT_W;
                end else if (axi2arb_rframe_valid) begin
                    state_d = GNT_R;
                end
            end
            GNT_W: begin
                if (eof_hs) begin
                    if (!WR_PRIO && frame_cnt_q == CNT_LAST) begin
                        state_d     = ARB;
                        frame_cnt_d = '0;
                        prio_rd_d   = 1'b1;
                    end else if (!WR_PRIO) begin
                        frame_cnt_d = frame_cnt_q + CNT_ONE;
                    end
                end else if (!in_frame && !axi2arb_wframe_valid && axi2arb_rframe_valid) begin
                    state_d     = ARB;
                    frame_cnt_d = '0;
                    prio_rd_d   = 1'b1;
                end
            end
            GNT_R: begin
                if (eof_hs) begin
                    if (frame_cnt_q == CNT_LAST) begin
                        state_d     = ARB;
                        frame_cnt_d = '0;
                        prio_rd_d   = 1'b0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CNT_ONE;
                    end
                end else if (!in_frame && !axi2arb_rframe_valid && axi2arb_wframe_valid) begin
                    state_d     = ARB;
                    frame_cnt_d = '0;
                    prio_rd_d   = 1'b0;
                end
            end
            default: begin
                state_d     = ARB;
                frame_cnt_d = '0;
            end
        endcase

        // grant flags track the next state so they line up with state_q
        gnt_wr_d = (state_d == GNT_W);
        gnt_rd_d = (state_d == GNT_R);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB;
            prio_rd_q   <= 1'b0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
            gnt_wr_q    <= 1'b0;
            gnt_rd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_rd_q   <= prio_rd_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
            gnt_wr_q    <= gnt_wr_d;
            gnt_rd_q    <= gnt_rd_d;
        end
    end

    assign arb_gnt_wr = gnt_wr_q;
    assign arb_gnt_rd = gnt_rd_q;
    assign arb_err    = err_q;

endmodule

// File: tb/tb_mem_frame_arbiter.sv
// Scoreboard bench for mem_frame_arbiter: queued expected beats and per-cycle grant traces.
module tb_mem_frame_arbiter;
    import mem_frame_pkg::*;

    localparam int GF = 4;
`ifdef ARB_WR_PRIORITY_EN
    localparam bit WR_PRIO = 1'b1;
`else
    localparam bit WR_PRIO = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   axi2arb_wframe_valid;
    logic                   axi2arb_wframe_ready;
    logic [FRAME_WIDTH-1:0] axi2arb_wframe_data;
    logic                   axi2arb_rframe_valid;
    logic                   axi2arb_rframe_ready;
    logic [FRAME_WIDTH-1:0] axi2arb_rframe_data;
    logic                   arb2mc_frame_valid;
    logic                   arb2mc_frame_ready;
    logic [FRAME_WIDTH-1:0] arb2mc_frame_data;
    logic                   arb_gnt_wr;
    logic                   arb_gnt_rd;
    logic                   arb_err;

    mem_frame_arbiter #(.FRAME_WIDTH(FRAME_WIDTH), .GRANT_FRAMES(GF), .CNT_WIDTH(8)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .axi2arb_wframe_valid (axi2arb_wframe_valid),
        .axi2arb_wframe_ready (axi2arb_wframe_ready),
        .axi2arb_wframe_data  (axi2arb_wframe_data),
        .axi2arb_rframe_valid (axi2arb_rframe_valid),
        .axi2arb_rframe_ready (axi2arb_rframe_ready),
        .axi2arb_rframe_data  (axi2arb_rframe_data),
        .arb2mc_frame_valid   (arb2mc_frame_valid),
        .arb2mc_frame_ready   (arb2mc_frame_ready),
        .arb2mc_frame_data    (arb2mc_frame_data),
        .arb_gnt_wr           (arb_gnt_wr),
        .arb_gnt_rd           (arb_gnt_rd),
        .arb_err              (arb_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [FRAME_WIDTH-1:0] src_w[$], src_r[$];
    logic [FRAME_WIDTH-1:0] exp_w[$], exp_r[$];
    logic [2:0]             exp_cyc[$];    // {hs, gnt_rd, gnt_wr} expected per cycle
    logic [1:0]             tr_gnt[$];
    bit                     tr_hs[$], tr_rr[$];

    bit en_w, en_r, rand_en;
    int rdy_mode;   // 0 held by main, 1 toggle, 2 random
    bit tb_in_frm, tb_frm_src;
    int grant_frames;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    endtask

    function automatic logic [FRAME_WIDTH-1:0] mk_beat(bit wr, bit sof, bit eof, int len);
        logic [63:0] d;
        logic [21:0] a;
        d = {$urandom, $urandom};
        a = 22'($urandom);
        return {8'(len), eof, sof, wr, d, a};
    endfunction

    task automatic push_frame(bit is_rd, int n, bit bad_sof);
        logic [FRAME_WIDTH-1:0] b;
        for (int i = 0; i < n; i++) begin
            b = mk_beat(!is_rd, (i == 0) && !bad_sof, i == n - 1, n);
            if (is_rd) begin src_r.push_back(b); exp_r.push_back(b); end
            else       begin src_w.push_back(b); exp_w.push_back(b); end
        end
    endtask

    function automatic logic [1:0] tr_at(int i);
        if (i < 0 || i >= tr_gnt.size()) return 2'b11;
        return tr_gnt[i];
    endfunction

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        src_w.delete(); src_r.delete(); exp_w.delete(); exp_r.delete();
        exp_cyc.delete(); tr_gnt.delete(); tr_hs.delete(); tr_rr.delete();
        en_w = 0; en_r = 0; rand_en = 0; rdy_mode = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_all();
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic wait_drain(string nm, int maxc);
        int n = 0;
        while ((exp_w.size() != 0 || exp_r.size() != 0) && n < maxc) begin cyc(1); n++; end
        chk(nm, exp_w.size() + exp_r.size(), 0);
    endtask

    // source driver: advance on the handshake seen just before each rising edge
    initial begin
        bit w_hs_s, r_hs_s;
        axi2arb_wframe_valid = 0; axi2arb_wframe_data = '0;
        axi2arb_rframe_valid = 0; axi2arb_rframe_data = '0;
        forever begin
            @(negedge clk);
            w_hs_s = axi2arb_wframe_valid & axi2arb_wframe_ready;
            r_hs_s = axi2arb_rframe_valid & axi2arb_rframe_ready;
            @(posedge clk);
            #2;
            if (rst) begin
                axi2arb_wframe_valid = 0; axi2arb_wframe_data = '0;
                axi2arb_rframe_valid = 0; axi2arb_rframe_data = '0;
                continue;
            end
            if (w_hs_s && src_w.size() > 0) void'(src_w.pop_front());
            if (r_hs_s && src_r.size() > 0) void'(src_r.pop_front());
            if (rand_en) begin
                en_w = ($urandom_range(0, 3) != 0);
                en_r = ($urandom_range(0, 3) != 0);
            end
            axi2arb_wframe_valid = en_w && (src_w.size() > 0);
            axi2arb_wframe_data  = axi2arb_wframe_valid ? src_w[0] : '0;
            axi2arb_rframe_valid = en_r && (src_r.size() > 0);
            axi2arb_rframe_data  = axi2arb_rframe_valid ? src_r[0] : '0;
            if (rdy_mode == 1) arb2mc_frame_ready = ~arb2mc_frame_ready;
            else if (rdy_mode == 2) arb2mc_frame_ready = 1'($urandom_range(0, 1));
        end
    end

    // monitor: pops expected beats / cycle records whenever the DUT presents them
    initial begin
        logic [1:0] gnt;
        logic       hs;
        logic [2:0] ec;
        logic [FRAME_WIDTH-1:0] e;
        bit src;
        forever begin
            @(negedge clk);
            if (rst) begin tb_in_frm = 0; grant_frames = 0; continue; end
            gnt = {arb_gnt_rd, arb_gnt_wr};
            hs  = arb2mc_frame_valid & arb2mc_frame_ready;
            tr_gnt.push_back(gnt); tr_hs.push_back(hs); tr_rr.push_back(axi2arb_rframe_ready);
            chk("ready_gate", {axi2arb_wframe_ready & ~arb_gnt_wr,
                               axi2arb_rframe_ready & ~arb_gnt_rd, arb_gnt_wr & arb_gnt_rd}, 0);
            if (gnt == 2'b00) grant_frames = 0;
            if (exp_cyc.size() > 0) begin
                ec = exp_cyc.pop_front();
                chk("cycle_trace", {hs, gnt}, ec);
            end
            if (hs) begin
                chk("hs_has_grant", (gnt == 2'b01) || (gnt == 2'b10), 1);
                src = gnt[1];
                if (!src) begin
                    chk("w_beat_expected", exp_w.size() != 0, 1);
                    if (exp_w.size() != 0) begin e = exp_w.pop_front(); chk("w_beat_data", arb2mc_frame_data, e); end
                end else begin
                    chk("r_beat_expected", exp_r.size() != 0, 1);
                    if (exp_r.size() != 0) begin e = exp_r.pop_front(); chk("r_beat_data", arb2mc_frame_data, e); end
                end
                if (tb_in_frm) chk("frame_lock", src, tb_frm_src);
                else begin tb_in_frm = 1; tb_frm_src = src; end
                if (arb2mc_frame_data[FR_EOF_BIT]) begin
                    tb_in_frm = 0;
                    grant_frames++;
                    if (!(WR_PRIO && !src)) chk("grant_limit", grant_frames <= GF, 1);
                end
            end
        end
    end

    initial begin
        int n, idx, nw, nrb, nrr;
        rst = 1'b1;
        arb2mc_frame_ready = 1'b0;
        clear_all();
        cyc(2);
        chk("reset_outs", {arb2mc_frame_valid, axi2arb_wframe_ready, axi2arb_rframe_ready,
                           arb_gnt_wr, arb_gnt_rd, arb_err}, 0);
        chk("reset_data", arb2mc_frame_data, 0);
        rst = 1'b0;

        // write only: one bubble then 12 back-to-back beats
        arb2mc_frame_ready = 1'b1;
        exp_cyc.push_back(3'b000);
        for (int i = 0; i < 12; i++) exp_cyc.push_back(3'b101);
        for (int i = 0; i < 3; i++) push_frame(0, 4, 0);
        en_w = 1;
        wait_drain("t1_drain", 40);
        chk("t1_err", arb_err, 0);

        // both sources saturated with single-beat frames
        do_reset();
        arb2mc_frame_ready = 1'b1;
        if (WR_PRIO) begin
            exp_cyc.push_back(3'b000);
            for (int i = 0; i < 10; i++) exp_cyc.push_back(3'b101);
        end else begin
            for (int blk = 0; blk < 3; blk++) begin
                exp_cyc.push_back(3'b000);
                for (int i = 0; i < GF; i++) exp_cyc.push_back((blk % 2) ? 3'b110 : 3'b101);
            end
        end
        for (int i = 0; i < 10; i++) begin push_frame(0, 1, 0); push_frame(1, 1, 0); end
        en_w = 1; en_r = 1;
        wait_drain("t2_drain", 100);
        chk("t2_trace_consumed", exp_cyc.size(), 0);

        // read arrives mid write frame with toggling ready; then write idles
        do_reset();
        arb2mc_frame_ready = 1'b1;
        rdy_mode = 1;
        push_frame(0, 4, 0);
        en_w = 1;
        n = 0;
        while (exp_w.size() > 2 && n < 40) begin cyc(1); n++; end
        push_frame(1, 4, 0);
        en_r = 1;
        wait_drain("t3_drain", 100);
        idx = -1; nw = 0; nrb = 0; nrr = 0;
        for (int i = 0; i < tr_gnt.size(); i++) begin
            if (idx < 0) begin
                if (tr_rr[i]) nrr++;
                if (tr_hs[i] && tr_gnt[i] == 2'b10) nrb++;
                if (tr_hs[i] && tr_gnt[i] == 2'b01) begin nw++; if (nw == 4) idx = i; end
            end
        end
        chk("t3_w_frame_done", nw, 4);
        chk("t3_no_r_beat_first", nrb, 0);
        chk("t3_r_ready_low", nrr, 0);
        chk("t3_idle_cycle", tr_at(idx + 1), 2'b01);
        chk("t3_arb_cycle", tr_at(idx + 2), 2'b00);
        chk("t3_r_grant", tr_at(idx + 3), 2'b10);
        rdy_mode = 0;

        // framing error: first beat without sof
        do_reset();
        chk("err_after_reset", arb_err, 0);
        arb2mc_frame_ready = 1'b1;
        push_frame(0, 2, 1);
        en_w = 1;
        n = 0;
        while (exp_w.size() > 1 && n < 20) begin cyc(1); n++; end
        chk("err_set", arb_err, 1);
        push_frame(0, 2, 0);
        wait_drain("t5_drain", 40);
        chk("err_sticky", arb_err, 1);
        do_reset();
        chk("err_cleared", arb_err, 0);

        // asynchronous reset during beat 2 of a read frame
        arb2mc_frame_ready = 1'b1;
        push_frame(0, 1, 0);
        push_frame(1, 4, 0);
        en_w = 1; en_r = 1;
        n = 0;
        while (exp_r.size() > 3 && n < 30) begin cyc(1); n++; end
        chk("t6_mid_read", {arb_gnt_rd, exp_r.size()}, {1'b1, 32'd3});
        rst = 1'b1;
        #1;
        chk("t6_async_outs", {arb2mc_frame_valid, axi2arb_wframe_ready, axi2arb_rframe_ready,
                              arb_gnt_wr, arb_gnt_rd, arb_err}, 0);
        chk("t6_async_data", arb2mc_frame_data, 0);
        clear_all();
        cyc(2);
        rst = 1'b0;
        exp_cyc.push_back(3'b000);
        exp_cyc.push_back(3'b101);
        push_frame(0, 1, 0);
        push_frame(1, 1, 0);
        en_w = 1; en_r = 1;
        wait_drain("t6_drain", 40);
        chk("t6_trace_consumed", exp_cyc.size(), 0);

        // randomized traffic, random gaps and backpressure
        do_reset();
        rdy_mode = 2;
        rand_en = 1;
        for (int k = 0; k < 40; k++) push_frame(1'($urandom_range(0, 1)), $urandom_range(1, 5), 0);
        wait_drain("t7_drain", 3000);
        chk("t7_err", arb_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
